serial_subtractor_8bit: RTL and testbench

Bit-serial subtractor that computes diff = a - b - bin, producing a difference and a borrow-out. It is the inverse-direction companion to the team's 8-bit adder: given a sum and one operand, it recovers the other.
It processes one bit per clock, LSB first, under a start/done handshake. It is intended for area-constrained datapaths where a full parallel subtractor is not justified.

---
 rtl/serial_subtractor_8bit_pkg.sv | 20 ++
 rtl/serial_subtractor_8bit_full_subtractor_bit.sv | 13 +
 rtl/serial_subtractor_8bit.sv | 129 ++++++++++++
 tb/tb_serial_subtractor_8bit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, the default width and the counter sizing rule.
package sub_pkg;

    localparam int DEF_WIDTH = 8;

    // The counter has to be able to hold WIDTH itself, not only WIDTH-1.
    localparam int CNT_W = $clog2(DEF_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_8bit_full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - br, with the borrow rippling out on br_o.
module full_subtractor_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic d_o,
    output logic br_o
);

    assign d_o  = a_i ^ b_i ^ br_i;
    assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor computing diff = a - b - bin, one bit per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor_8bit
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;

    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

`ifdef SUB_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
`endif

    full_subtractor_bit u_cell (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .br_i (br_q),
        .d_o  (d_bit),
        .br_o (br_d)
    );

    // Result fills from the top, so after WIDTH shifts bit 0 sits at the LSB.
    assign res_d = {d_bit, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
`ifdef SUB_OVERFLOW_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    br_q   <= br_d;
                    res_q  <= res_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Final bit is the MSB; publish the whole result on this edge.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bout_q  <= br_d;
`ifdef SUB_OVERFLOW_EN
                        ovf_q   <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: cycle-level model plus directed literal cases.
module tb_serial_subtractor_8bit;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_subtractor_8bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: edges elapsed since the accepted start decide busy/done;
  // the result is plain (W+1)-bit arithmetic.
  int           m_since = -1;
  logic [W:0]   m_pend  = '0;
  logic         m_povf  = 1'b0;
  logic [W-1:0] exp_diff = '0;
  logic         exp_bout = 1'b0;
  logic         exp_ovf  = 1'b0;
  logic [W:0]   exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_since  = -1;
      exp_diff = '0;
      exp_bout = 1'b0;
      exp_ovf  = 1'b0;
      exp_q.delete();
    end else if (m_since < 0) begin
      if (start) begin
        m_since = 0;
        m_pend  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        m_povf  = (a[W-1] ^ b[W-1]) & (a[W-1] ^ m_pend[W-1]);
        exp_q.push_back(m_pend);
      end
    end else begin
      m_since++;
      if (m_since == W) begin
        exp_diff = m_pend[W-1:0];
        exp_bout = m_pend[W];
        exp_ovf  = m_povf;
      end else if (m_since > W) begin
        m_since = -1;
      end
    end
  end

  // Compare process: every cycle, just after the active edge.
  always @(posedge clk) begin
    logic [W:0] q;
    #1;
    chk("busy", 32'(busy), 32'(m_since >= 0 && m_since < W));
    chk("done", 32'(done), 32'(m_since == W));
    chk("diff", 32'(diff), 32'(exp_diff));
    chk("bout", 32'(bout), 32'(exp_bout));
`ifdef SUB_OVERFLOW_EN
    chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    if (done && !rst) begin
      if (exp_q.size() == 0) begin
        chk("sb_spurious_done", 32'(1), 32'(0));
      end else begin
        q = exp_q.pop_front();
        chk("sb_result", 32'({bout, diff}), 32'(q));
      end
    end
  end

  // driver tasks
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input string nm);
    bit seen = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= W + 4; n++) begin
      @(posedge clk); #1;
      if (done) begin
        chk({nm, "_latency"}, 32'(n), 32'(W));
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_bout"}, 32'(bout), 32'(eb));
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic rand_op();
    bit seen = 1'b0;
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1)); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= W + 4; n++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
        break;
      end
      // Noise while busy must be ignored.
      start = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
    end
    if (!seen) chk("rand_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    logic [W-1:0] got;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_diff", 32'(diff), 32'(0));
    chk("reset_bout", 32'(bout), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "op_05_03");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "op_00_01");
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "op_FF_FF_1");
    do_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "op_FF_00");
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "op_00_00_1");
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b0, "op_80_80");
`ifdef SUB_OVERFLOW_EN
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "op_ovf1");
    chk("ovf_80_01", 32'(ovf), 32'(1));
    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "op_ovf0");
    chk("ovf_05_03", 32'(ovf), 32'(0));
`endif

    // Start pulse mid-operation must not disturb the op in flight.
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignore_busy", 32'(busy), 32'(1));
    dones = 0;
    got = '0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        got = diff;
      end
    end
    chk("ignore_done_count", 32'(dones), 32'(1));
    chk("ignore_diff", 32'(got), 32'(8'h0F));

    // Reset in the fourth SHIFT cycle aborts at once.
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_diff", 32'(diff), 32'(0));
    chk("midrst_bout", 32'(bout), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, "op_after_rst");

    // Back-to-back random operations, checked by the model each cycle.
    for (int i = 0; i < 3000; i++) rand_op();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
